float_to_fixed_sat: RTL and testbench

Downstream stage of the floating-point polynomial estimator. Accepts IEEE-754 single-precision samples on a valid/ready stream, converts each to a signed fixed-point word with round-to-nearest and saturation, and emits it on a valid/ready stream toward the fixed-point audio datapath. Fully pipelined at one sample per clock, with backpressure.

---
 rtl/fp_conv_pkg.sv | 34 +++
 rtl/fp_round_saturate.sv | 56 +++++
 rtl/float_to_fixed_sat.sv | 128 ++++++++++++
 tb/tb_float_to_fixed_sat.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_conv_pkg.sv
// Shared IEEE-754 single-precision field definitions and input classification
// for the float-to-fixed conversion stages.
package fp_conv_pkg;

   typedef logic [31:0] float_t;

   localparam int FP_EXP_BIAS  = 127;
   localparam int FP_MANT_BITS = 23;
   localparam int FP_SIGN_POS  = 31;
   localparam int FP_EXP_MSB   = 30;
   localparam int FP_EXP_LSB   = 23;
   localparam int FP_MANT_MSB  = 22;
   localparam int FP_MANT_LSB  = 0;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORMAL,
      FP_INF,
      FP_NAN
   } fp_class_t;

   // Subnormals fall into FP_ZERO because they are flushed to zero downstream.
   function automatic fp_class_t fp_classify(input float_t f);
      fp_class_t cls;
      if (f[FP_EXP_MSB:FP_EXP_LSB] == 8'h00)
         cls = FP_ZERO;
      else if (f[FP_EXP_MSB:FP_EXP_LSB] == 8'hFF)
         cls = (f[FP_MANT_MSB:FP_MANT_LSB] == '0) ? FP_INF : FP_NAN;
      else
         cls = FP_NORMAL;
      return cls;
   endfunction

endpackage

// File: rtl/fp_round_saturate.sv
// Final conversion stage: rounds the aligned magnitude, clamps to the signed output
// range and applies the sign. The sat flag port exists only with FLOAT_SAT_COUNT_EN.
module fp_round_saturate #(
   parameter int G_DOUT_WIDTH = 24
) (
   input  logic                    clk,
   input  logic                    clear,
   input  logic                    advance,
   input  logic                    stage_valid,
   input  logic                    sign,
   input  logic [G_DOUT_WIDTH-1:0] mag,
   input  logic                    guard,
   input  logic                    ovf,
   output logic [G_DOUT_WIDTH-1:0] dout,
   output logic                    dout_valid
`ifdef FLOAT_SAT_COUNT_EN
   ,
   output logic                    sat
`endif
);

   // Negative results may reach one LSB further than positive ones.
   localparam logic [G_DOUT_WIDTH:0] POS_LIMIT = {2'b00, {(G_DOUT_WIDTH-1){1'b1}}};
   localparam logic [G_DOUT_WIDTH:0] NEG_LIMIT = {2'b01, {(G_DOUT_WIDTH-1){1'b0}}};

   logic [G_DOUT_WIDTH:0]   rounded;
   logic                    clamp;
   logic [G_DOUT_WIDTH-1:0] value;

   always_comb begin
      rounded = {1'b0, mag} + {{G_DOUT_WIDTH{1'b0}}, guard};
      clamp   = ovf || (sign ? (rounded > NEG_LIMIT) : (rounded > POS_LIMIT));
      value   = '0;
      if (clamp)
         value = sign ? {1'b1, {(G_DOUT_WIDTH-1){1'b0}}} : {1'b0, {(G_DOUT_WIDTH-1){1'b1}}};
      else
         value = sign ? -rounded[G_DOUT_WIDTH-1:0] : rounded[G_DOUT_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         dout_valid <= 1'b0;
         dout       <= '0;
`ifdef FLOAT_SAT_COUNT_EN
         sat        <= 1'b0;
`endif
      end else if (advance) begin
         dout_valid <= stage_valid;
         dout       <= value;
`ifdef FLOAT_SAT_COUNT_EN
         sat        <= clamp && stage_valid;
`endif
      end
   end

endmodule

// File: rtl/float_to_fixed_sat.sv
// Three-stage IEEE-754 single to signed fixed-point converter with round-to-nearest,
// saturation and valid/ready backpressure. FLOAT_SAT_COUNT_EN adds the sat_count port.
module float_to_fixed_sat
   import fp_conv_pkg::*;
#(
   parameter int G_DOUT_WIDTH = 24,
   parameter int G_FRAC_BITS  = 23
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [31:0]             din,
   input  logic                    din_valid,
   output logic                    din_ready,
   output logic [G_DOUT_WIDTH-1:0] dout,
   output logic                    dout_valid,
   input  logic                    dout_ready
`ifdef FLOAT_SAT_COUNT_EN
   ,
   output logic [15:0]             sat_count
`endif
);

   logic flush;
   logic advance;

   assign flush     = !reset_n || !enable;
   assign advance   = !dout_valid || dout_ready;
   assign din_ready = advance && !flush;

   logic        s1_valid;
   logic        s1_sign;
   logic [7:0]  s1_exp;
   logic [23:0] s1_mant;
   fp_class_t   s1_class;

   // Unpack: mantissa is stored with the hidden bit already restored.
   always_ff @(posedge clk) begin
      if (flush) begin
         s1_valid <= 1'b0;
      end else if (advance) begin
         s1_valid <= din_valid;
         s1_sign  <= din[FP_SIGN_POS];
         s1_exp   <= din[FP_EXP_MSB:FP_EXP_LSB];
         s1_mant  <= {1'b1, din[FP_MANT_MSB:FP_MANT_LSB]};
         s1_class <= fp_classify(din);
      end
   end

   int                      shift_amt;
   logic                    ovf_c;
   logic                    guard_c;
   logic [G_DOUT_WIDTH-1:0] mag_c;

   // Overflow whenever the leading mantissa bit lands at or above bit G_DOUT_WIDTH.
   always_comb begin
      shift_amt = int'(s1_exp) - FP_EXP_BIAS - FP_MANT_BITS + G_FRAC_BITS;
      ovf_c     = 1'b0;
      guard_c   = 1'b0;
      mag_c     = '0;
      case (s1_class)
         FP_INF: ovf_c = 1'b1;
         FP_NORMAL: begin
            if (shift_amt + FP_MANT_BITS >= G_DOUT_WIDTH) begin
               ovf_c = 1'b1;
            end else if (shift_amt >= 0) begin
               mag_c = G_DOUT_WIDTH'({8'h00, s1_mant} << 5'(shift_amt));
            end else if (shift_amt > -25) begin
               mag_c   = G_DOUT_WIDTH'({8'h00, s1_mant} >> 5'(-shift_amt));
               guard_c = s1_mant[5'(-shift_amt - 1)];
            end
         end
         default: ;
      endcase
   end

   logic                    s2_valid;
   logic                    s2_sign;
   logic [G_DOUT_WIDTH-1:0] s2_mag;
   logic                    s2_guard;
   logic                    s2_ovf;

   always_ff @(posedge clk) begin
      if (flush) begin
         s2_valid <= 1'b0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_mag   <= mag_c;
         s2_guard <= guard_c;
         s2_ovf   <= ovf_c;
      end
   end

`ifdef FLOAT_SAT_COUNT_EN
   logic dout_sat;
`endif

   fp_round_saturate #(
      .G_DOUT_WIDTH(G_DOUT_WIDTH)
   ) u_round_saturate (
      .clk        (clk),
      .clear      (flush),
      .advance    (advance),
      .stage_valid(s2_valid),
      .sign       (s2_sign),
      .mag        (s2_mag),
      .guard      (s2_guard),
      .ovf        (s2_ovf),
      .dout       (dout),
      .dout_valid (dout_valid)
`ifdef FLOAT_SAT_COUNT_EN
      ,
      .sat        (dout_sat)
`endif
   );

`ifdef FLOAT_SAT_COUNT_EN
   // Only a true reset clears the counter; enable=0 leaves it intact.
   always_ff @(posedge clk) begin
      if (!reset_n)
         sat_count <= '0;
      else if (dout_valid && dout_ready && dout_sat && sat_count != 16'hFFFF)
         sat_count <= sat_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_float_to_fixed_sat.sv
// Scoreboard bench for float_to_fixed_sat: a real-arithmetic model queues expected words
// on input transfers and a monitor compares them on output transfers (W=24/F=23 and W=16/F=0).
module tb_float_to_fixed_sat;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, enable;
   logic [31:0] din;
   logic        din_valid, din_ready;
   logic [23:0] dout;
   logic        dout_valid, dout_ready;
   logic [31:0] din16;
   logic        din16_valid, din16_ready;
   logic [15:0] dout16;
   logic        dout16_valid, dout16_ready;
`ifdef FLOAT_SAT_COUNT_EN
   logic [15:0] sat_count, sat_count16;
`endif

   float_to_fixed_sat dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
`ifdef FLOAT_SAT_COUNT_EN
      , .sat_count(sat_count)
`endif
   );

   float_to_fixed_sat #(.G_DOUT_WIDTH(16), .G_FRAC_BITS(0)) dut16 (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .din(din16), .din_valid(din16_valid), .din_ready(din16_ready),
      .dout(dout16), .dout_valid(dout16_valid), .dout_ready(dout16_ready)
`ifdef FLOAT_SAT_COUNT_EN
      , .sat_count(sat_count16)
`endif
   );

   typedef struct {
      logic [31:0] val;
      bit          sat;
   } exp_t;

   exp_t q[$];
   exp_t q16[$];
   int   checks = 0;
   int   failures = 0;
   int   sat_model = 0;
   int   sat_model16 = 0;
   bit   rand_ready_en = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
      end
   endtask

   function automatic real pow2(input int e);
      real p = 1.0;
      if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
      else        for (int i = 0; i < -e; i++) p = p / 2.0;
      return p;
   endfunction

   // Reference: clamp(round_half_away(|v| * 2^F) with sign, output range).
   function automatic void model(input logic [31:0] f, input int w, input int fb,
                                 output logic [31:0] res, output bit sat);
      int     e    = int'(f[30:23]);
      int     frac = int'(f[22:0]);
      real    maxv = pow2(w - 1) - 1.0;
      real    minv = -pow2(w - 1);
      real    r    = 0.0;
      real    m;
      longint li;
      logic [31:0] mask;
      sat = 1'b0;
      if (e == 255 && frac == 0) begin
         r   = f[31] ? minv : maxv;
         sat = 1'b1;
      end else if (e != 0 && e != 255) begin
         m = $floor((8388608.0 + real'(frac)) * pow2(e - 150 + fb) + 0.5);
         r = f[31] ? -m : m;
         if (r > maxv) begin r = maxv; sat = 1'b1; end
         if (r < minv) begin r = minv; sat = 1'b1; end
      end
      li   = longint'(r);
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      res  = li[31:0] & mask;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (reset_n && din_valid && din_ready) begin
         model(din, 24, 23, e.val, e.sat);
         q.push_back(e);
      end
      if (reset_n && din16_valid && din16_ready) begin
         model(din16, 16, 0, e.val, e.sat);
         q16.push_back(e);
      end
   end

   logic [23:0] held;
   bit          held_v = 1'b0;

   // Reset discards in-flight samples, so their expectations are dropped too.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         q.delete();
         q16.delete();
         held_v      = 1'b0;
         sat_model   = 0;
         sat_model16 = 0;
      end else begin
         if (held_v) begin
            checkOutput("stall_valid", {31'd0, dout_valid}, 32'd1);
            checkOutput("stall_data", {8'd0, dout}, {8'd0, held});
         end
         if (dout_valid && dout_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_dout actual=0x%0h required=no_output", dout);
            end else begin
               e = q.pop_front();
               checks--;
               checkOutput("dout", {8'd0, dout}, e.val);
               if (e.sat) sat_model++;
            end
         end
         held_v = dout_valid && !dout_ready;
         held   = dout;
         if (dout16_valid && dout16_ready) begin
            checks++;
            if (q16.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_dout16 actual=0x%0h required=no_output", dout16);
            end else begin
               e = q16.pop_front();
               checks--;
               checkOutput("dout16", {16'd0, dout16}, e.val);
               if (e.sat) sat_model16++;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready_en) dout_ready = ($urandom_range(0, 2) != 0);
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic applyStimulus(input bit sel16, input logic [31:0] f);
      bit ok = 1'b0;
      if (sel16) begin din16 = f; din16_valid = 1'b1; end
      else       begin din = f;   din_valid = 1'b1;   end
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = sel16 ? din16_ready : din_ready;
         @(posedge clk);
         #1;
      end
      din_valid   = 1'b0;
      din16_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("[TB] FAIL accept_timeout actual=no_ready required=din_ready");
      end
   endtask

   task automatic waitDrain();
      int i = 0;
      while ((q.size() != 0 || q16.size() != 0) && i < 2000) begin
         @(posedge clk);
         i++;
      end
      #1;
      checkOutput("drain_queue_empty", q.size() + q16.size(), 0);
   endtask

   function automatic logic [31:0] randFloat();
      logic [31:0] specials [8] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h7F80_0000,
                                    32'hFF80_0000, 32'h7FC0_0000, 32'hFFC0_1234, 32'h3380_0000};
      if ($urandom_range(0, 15) == 0) return specials[$urandom_range(0, 7)];
      return {1'($urandom_range(0, 1)), 8'($urandom_range(95, 160)), 23'($urandom)};
   endfunction

   logic [31:0] dir_tbl [11] = '{32'hBF00_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h7F80_0000,
                                 32'h7FC0_0000, 32'h3380_0000, 32'hB380_0000, 32'h3340_0000,
                                 32'h3280_0000, 32'h0000_0001, 32'hFF80_0000};
   logic [31:0] dir16_tbl [5] = '{32'h42F6_0000, 32'h4780_0000, 32'hC700_0000, 32'h3F40_0000, 32'hBFC0_0000};

   initial begin
      int lat;
      int seen;
      reset_n = 1'b0; enable = 1'b1;
      din = '0; din_valid = 1'b0; dout_ready = 1'b1;
      din16 = '0; din16_valid = 1'b0; dout16_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_dout_valid", {31'd0, dout_valid}, 32'd0);
      checkOutput("reset_din_ready", {31'd0, din_ready}, 32'd0);
      checkOutput("reset_dout", {8'd0, dout}, 32'd0);
      checkOutput("reset_dout16_valid", {31'd0, dout16_valid}, 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_reset", {31'd0, din_ready}, 32'd1);
      @(posedge clk); #1;

      // Edges counted from the accepting edge (inclusive) to the first valid output.
      din = 32'h3F00_0000; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!dout_valid && lat < 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      checkOutput("latency_edges", lat, 3);
      @(posedge clk); #1;

      foreach (dir_tbl[i]) applyStimulus(1'b0, dir_tbl[i]);
      foreach (dir16_tbl[i]) applyStimulus(1'b1, dir16_tbl[i]);
      waitDrain();
`ifdef FLOAT_SAT_COUNT_EN
      checkOutput("sat_count_directed", {16'd0, sat_count}, sat_model);
      checkOutput("sat_count16_directed", {16'd0, sat_count16}, sat_model16);
`endif

      rand_ready_en = 1'b1;
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h3D00_0000 + 32'(i) * 32'h0008_0000);
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         applyStimulus(1'b0, randFloat());
         if ($urandom_range(0, 4) == 0) applyStimulus(1'b1, randFloat());
      end
      waitDrain();
      rand_ready_en = 1'b0;
      @(posedge clk); #1;
      dout_ready = 1'b1;
`ifdef FLOAT_SAT_COUNT_EN
      checkOutput("sat_count_random", {16'd0, sat_count}, sat_model);
`endif

      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h3F00_0000 + 32'(i));
      reset_n = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("flush_dout_valid", {31'd0, dout_valid}, 32'd0);
`ifdef FLOAT_SAT_COUNT_EN
      checkOutput("flush_sat_count", {16'd0, sat_count}, 32'd0);
`endif
      @(posedge clk); #1;
      reset_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (dout_valid) seen++;
      end
      checkOutput("flushed_samples_seen", seen, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 20; i++) applyStimulus(1'b0, randFloat());
      waitDrain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
